// File: rtl/pulse_voice.sv
// One square-wave synth voice: period timer, 8-step duty sequencer, volume and
// frame-clocked length counter, producing a registered 9-bit sample for the mixer.
module pulse_voice #(
  parameter int PERIOD_WIDTH = 11,
  parameter int MUTE_BELOW   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic [1:0]              i_duty,
  input  logic [3:0]              i_volume,
  input  logic [7:0]              i_length,
  input  logic                    i_trigger,
  input  logic                    i_frame_pulse,
  output logic [8:0]              o_output,
  output logic                    o_active,
  output logic                    o_period_tick
);

  localparam logic [PERIOD_WIDTH-1:0] TIMER_ZERO = PERIOD_WIDTH'(0);
  localparam logic [PERIOD_WIDTH-1:0] TIMER_ONE  = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] MUTE_LIMIT = PERIOD_WIDTH'(MUTE_BELOW);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;

  logic [PERIOD_WIDTH-1:0] timer_r;
  logic [PERIOD_WIDTH-1:0] timer_nxt_s;
  logic [2:0]              index_r;
  logic [2:0]              index_nxt_s;
  logic [7:0]              len_cnt_r;
  logic [7:0]              len_cnt_nxt_s;

  logic [PERIOD_WIDTH-1:0] period_r;
  logic [1:0]              duty_r;
  logic [3:0]              vol_r;
  logic [7:0]              length_r;

  logic                    active_s;
  logic                    expire_s;
  logic                    tick_nxt_s;
  logic [8:0]              sample_nxt_s;

  // Waveform shape: high on the last 1, 2, 4 or 6 of the 8 sequencer steps.
  function automatic logic duty_high(input logic [1:0] duty, input logic [2:0] idx);
    logic high;
    case (duty)
      2'b00:   high = (idx == 3'd7);
      2'b01:   high = (idx >= 3'd6);
      2'b10:   high = (idx >= 3'd4);
      2'b11:   high = (idx >= 3'd2);
      default: high = 1'b0;
    endcase
    return high;
  endfunction

  assign active_s = (state_r == ST_ACTIVE);
  // Only the decrement from 1 ends a note; sustain notes (length 0) never count.
  assign expire_s = i_frame_pulse && active_s && (length_r != 8'd0) && (len_cnt_r == 8'd1);

  // Voice state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a trigger always (re)starts the note and beats a same-cycle expiry.
  always_comb begin
    state_nxt_s = state_r;
    if (i_trigger) begin
      state_nxt_s = ST_ACTIVE;
    end else if (expire_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next timer, step index, length count, tick and sample from the current state.
  always_comb begin
    timer_nxt_s   = timer_r;
    index_nxt_s   = index_r;
    len_cnt_nxt_s = len_cnt_r;
    tick_nxt_s    = 1'b0;
    if (i_trigger) begin
      timer_nxt_s   = i_period;
      index_nxt_s   = 3'd0;
      len_cnt_nxt_s = i_length;
    end else if (active_s) begin
      if (timer_r == TIMER_ZERO) begin
        timer_nxt_s = period_r;
        index_nxt_s = index_r + 3'd1;
        tick_nxt_s  = 1'b1;
      end else begin
        timer_nxt_s = timer_r - TIMER_ONE;
        index_nxt_s = index_r;
        tick_nxt_s  = 1'b0;
      end
      if (i_frame_pulse && (length_r != 8'd0)) begin
        len_cnt_nxt_s = len_cnt_r - 8'd1;
      end else begin
        len_cnt_nxt_s = len_cnt_r;
      end
    end else begin
      timer_nxt_s   = timer_r;
      index_nxt_s   = index_r;
      len_cnt_nxt_s = len_cnt_r;
    end

    // Periods below the guard are ultrasonic: keep counting but emit silence.
    if (active_s && duty_high(duty_r, index_r) && (period_r >= MUTE_LIMIT)) begin
      sample_nxt_s = {1'b0, vol_r, 4'b0000};
    end else begin
      sample_nxt_s = 9'd0;
    end
  end

  // Timer, step index and length counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timer_r   <= TIMER_ZERO;
      index_r   <= 3'd0;
      len_cnt_r <= 8'd0;
    end else begin
      timer_r   <= timer_nxt_s;
      index_r   <= index_nxt_s;
      len_cnt_r <= len_cnt_nxt_s;
    end
  end

  // Note configuration, captured only on trigger.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      period_r <= TIMER_ZERO;
      duty_r   <= 2'b00;
      vol_r    <= 4'd0;
      length_r <= 8'd0;
    end else if (i_trigger) begin
      period_r <= i_period;
      duty_r   <= i_duty;
      vol_r    <= i_volume;
      length_r <= i_length;
    end else begin
      period_r <= period_r;
      duty_r   <= duty_r;
      vol_r    <= vol_r;
      length_r <= length_r;
    end
  end

  // Registered outputs, one clock behind the voice state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_output      <= 9'd0;
      o_active      <= 1'b0;
      o_period_tick <= 1'b0;
    end else begin
      o_output      <= sample_nxt_s;
      o_active      <= active_s;
      o_period_tick <= tick_nxt_s;
    end
  end

endmodule

// File: tb/tb_pulse_voice.sv
// Bench for pulse_voice: directed note scenarios plus random traffic, checked
// every cycle against an elapsed-clock arithmetic model of the voice.
module tb_pulse_voice;

  logic        i_clk;
  logic        i_rst_n;
  logic [10:0] i_period;
  logic [1:0]  i_duty;
  logic [3:0]  i_volume;
  logic [7:0]  i_length;
  logic        i_trigger;
  logic        i_frame_pulse;
  logic [8:0]  o_output;
  logic        o_active;
  logic        o_period_tick;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  // Model: note config, clocks counted while sounding, frames left.
  int m_active, m_n, m_left, m_per, m_duty, m_vol, m_len;
  int e_out, e_active, e_tick;
  int duty_thr [4] = '{7, 6, 4, 2};

  pulse_voice dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_period      (i_period),
    .i_duty        (i_duty),
    .i_volume      (i_volume),
    .i_length      (i_length),
    .i_trigger     (i_trigger),
    .i_frame_pulse (i_frame_pulse),
    .o_output      (o_output),
    .o_active      (o_active),
    .o_period_tick (o_period_tick)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compare_cnt++;
    if (obs !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Predicts the outputs seen after the coming edge from the inputs applied now.
  task automatic model_step(input logic rst_n, input logic trig, input logic frame,
                            input int per, input int duty, input int vol, input int len);
    int idx;
    if (!rst_n) begin
      m_active = 0; m_n = 0; m_left = 0;
      m_per = 0; m_duty = 0; m_vol = 0; m_len = 0;
      e_out = 0; e_active = 0; e_tick = 0;
    end else begin
      idx      = (m_n / (m_per + 1)) % 8;
      e_out    = (m_active != 0 && idx >= duty_thr[m_duty] && m_per >= 8) ? m_vol * 16 : 0;
      e_active = m_active;
      e_tick   = 0;
      if (trig) begin
        m_active = 1; m_n = 0; m_left = len;
        m_per = per; m_duty = duty; m_vol = vol; m_len = len;
      end else if (m_active != 0) begin
        m_n++;
        e_tick = (m_n % (m_per + 1) == 0) ? 1 : 0;
        if (frame && m_len != 0) begin
          m_left--;
          if (m_left == 0) m_active = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic rst_n, input logic trig, input logic frame,
                       input int per, input int duty, input int vol, input int len);
    i_rst_n       = rst_n;
    i_trigger     = trig;
    i_frame_pulse = frame;
    i_period      = per[10:0];
    i_duty        = duty[1:0];
    i_volume      = vol[3:0];
    i_length      = len[7:0];
    model_step(rst_n, trig, frame, per, duty, vol, len);
    @(posedge i_clk);
    @(negedge i_clk);
    check_value("output", 16'(o_output), 16'(e_out));
    check_value("active", 16'(o_active), 16'(e_active));
    check_value("period_tick", 16'(o_period_tick), 16'(e_tick));
  endtask

  // Non-trigger cycles carry junk config to show it is ignored.
  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, 1'b0, 1'b0, $urandom_range(0, 2047), $urandom_range(0, 3),
            $urandom_range(0, 15), $urandom_range(0, 255));
    end
  endtask

  task automatic trigger_note(input int per, input int duty, input int vol, input int len,
                              input logic frame);
    cycle(1'b1, 1'b1, frame, per, duty, vol, len);
  endtask

  initial begin
    // Reset held with trigger high, then one clock after release.
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 8, 2, 15, 0);
    run_idle(1);

    // 50% duty, sustain.
    trigger_note(8, 2, 15, 0, 1'b0);
    run_idle(160);

    // 12.5% duty.
    trigger_note(8, 0, 3, 0, 1'b0);
    run_idle(160);

    // Length expiry after two frame pulses, then frozen silence.
    trigger_note(9, 3, 7, 2, 1'b0);
    run_idle(100);
    cycle(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
    run_idle(100);
    cycle(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
    run_idle(60);

    // Muted period keeps ticking and stays active.
    trigger_note(5, 2, 15, 0, 1'b0);
    run_idle(60);

    // Trigger and frame in the same cycle, then a mid-waveform retrigger.
    trigger_note(8, 2, 15, 1, 1'b1);
    run_idle(40);
    trigger_note(8, 3, 10, 0, 1'b0);
    run_idle(90);

    // Reset mid-note aborts; sounding needs a fresh trigger.
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    run_idle(20);

    // Random traffic.
    for (int k = 0; k < 20000; k++) begin
      int per;
      per = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 20) : $urandom_range(21, 120);
      cycle(($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
            per, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
